// File: rtl/controlador_bomba.sv
// Irrigation pump sequencer: timed run in ms, mandatory cooldown, level-alarm fault latch.
// Commands are accepted only in IDLE; any other request is refused with a one-cycle pulse.
module controlador_bomba #(
    parameter int CYCLES_PER_MS = 50000,
    parameter int COOLDOWN_MS   = 2000,
    parameter int MAX_MS        = 60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd_tempo_ms,
    input  logic        cmd_valid,
    input  logic        alerta_nivel_baixo,
    input  logic        abort,
    input  logic        fault_clear,
    output logic        bomba_on,
    output logic        ocupado,
    output logic [15:0] tempo_restante_ms,
    output logic        ciclo_concluido,
    output logic        cmd_rejeitado,
    output logic        falha_nivel,
    output logic [15:0] total_ciclos
);

    localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam int CW = (COOLDOWN_MS > 1) ? $clog2(COOLDOWN_MS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES_PER_MS - 1);
    localparam logic [CW-1:0] CD_LAST  = CW'((COOLDOWN_MS > 0) ? COOLDOWN_MS - 1 : 0);
    localparam logic [15:0]   MAX_LOAD = (MAX_MS > 65535) ? 16'hFFFF : 16'(MAX_MS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        COOLDOWN = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pre, pre_nxt;
    logic [CW-1:0]   cd_cnt, cd_nxt;
    logic [15:0]     tempo_nxt, total_nxt;
    logic            conc_nxt, rej_nxt;
    logic            tick;

    assign tick        = (pre == PRE_LAST);
    assign ocupado     = (state != IDLE);
    assign falha_nivel = (state == FAULT);

    // Prescaler defaults to zero, so every state change restarts the ms grid.
    always_comb begin
        state_nxt = state;
        pre_nxt   = '0;
        cd_nxt    = cd_cnt;
        tempo_nxt = tempo_restante_ms;
        total_nxt = total_ciclos;
        conc_nxt  = 1'b0;
        rej_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (alerta_nivel_baixo) begin
                        rej_nxt   = 1'b1;
                        state_nxt = FAULT;
                    end else if (cmd_tempo_ms == 16'd0) begin
                        rej_nxt = 1'b1;
                    end else begin
                        tempo_nxt = (cmd_tempo_ms > MAX_LOAD) ? MAX_LOAD : cmd_tempo_ms;
                        state_nxt = RUN;
                    end
                end else if (alerta_nivel_baixo) begin
                    state_nxt = FAULT;
                end
            end
            RUN: begin
                rej_nxt = cmd_valid;
                if (alerta_nivel_baixo) begin
                    state_nxt = FAULT;
                    tempo_nxt = 16'd0;
                end else if (abort) begin
                    state_nxt = COOLDOWN;
                    tempo_nxt = 16'd0;
                    cd_nxt    = '0;
                end else if (tick) begin
                    // <= 1 rather than == 1 keeps the counter from ever wrapping below zero
                    if (tempo_restante_ms <= 16'd1) begin
                        state_nxt = COOLDOWN;
                        tempo_nxt = 16'd0;
                        cd_nxt    = '0;
                        conc_nxt  = 1'b1;
                        total_nxt = (total_ciclos == 16'hFFFF) ? total_ciclos : total_ciclos + 16'd1;
                    end else begin
                        tempo_nxt = tempo_restante_ms - 16'd1;
                    end
                end else begin
                    pre_nxt = pre + 1'b1;
                end
            end
            COOLDOWN: begin
                rej_nxt = cmd_valid;
                if (alerta_nivel_baixo) begin
                    state_nxt = FAULT;
                end else if (tick) begin
                    if (cd_cnt >= CD_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        cd_nxt = cd_cnt + 1'b1;
                    end
                end else begin
                    pre_nxt = pre + 1'b1;
                end
            end
            FAULT: begin
                rej_nxt   = cmd_valid;
                tempo_nxt = 16'd0;
                if (fault_clear && !alerta_nivel_baixo) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                tempo_nxt = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            pre               <= '0;
            cd_cnt            <= '0;
            tempo_restante_ms <= 16'd0;
            total_ciclos      <= 16'd0;
            ciclo_concluido   <= 1'b0;
            cmd_rejeitado     <= 1'b0;
            bomba_on          <= 1'b0;
        end else begin
            state             <= state_nxt;
            pre               <= pre_nxt;
            cd_cnt            <= cd_nxt;
            tempo_restante_ms <= tempo_nxt;
            total_ciclos      <= total_nxt;
            ciclo_concluido   <= conc_nxt;
            cmd_rejeitado     <= rej_nxt;
            bomba_on          <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_controlador_bomba.sv
// Bench for controlador_bomba: directed scenarios plus random traffic against a cycle-count model.
module tb_controlador_bomba;

    localparam int C  = 4;
    localparam int CD = 3;
    localparam int MX = 100;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_COOL  = 2;
    localparam int M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] cmd_tempo_ms = 16'd0;
    logic        cmd_valid = 1'b0;
    logic        alerta = 1'b0;
    logic        abort = 1'b0;
    logic        fault_clear = 1'b0;
    logic        bomba_on, ocupado, ciclo_concluido, cmd_rejeitado, falha_nivel;
    logic [15:0] tempo_restante_ms, total_ciclos;

    controlador_bomba #(
        .CYCLES_PER_MS(C),
        .COOLDOWN_MS  (CD),
        .MAX_MS       (MX)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_tempo_ms      (cmd_tempo_ms),
        .cmd_valid         (cmd_valid),
        .alerta_nivel_baixo(alerta),
        .abort             (abort),
        .fault_clear       (fault_clear),
        .bomba_on          (bomba_on),
        .ocupado           (ocupado),
        .tempo_restante_ms (tempo_restante_ms),
        .ciclo_concluido   (ciclo_concluido),
        .cmd_rejeitado     (cmd_rejeitado),
        .falha_nivel       (falha_nivel),
        .total_ciclos      (total_ciclos)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model tracks remaining cycles of each phase; remaining ms is derived by rounding up.
    int          m_mode, m_run_left, m_cd_left, m_total;
    logic        m_conc, m_rej;
    logic [36:0] exp_vec;
    logic [36:0] obs;

    assign obs = {bomba_on, ocupado, falha_nivel, ciclo_concluido, cmd_rejeitado,
                  tempo_restante_ms, total_ciclos};

    task automatic model_outs();
        int t;
        t = (m_mode == M_RUN) ? (m_run_left + C - 1) / C : 0;
        exp_vec = {(m_mode == M_RUN), (m_mode != M_IDLE), (m_mode == M_FAULT),
                   m_conc, m_rej, 16'(t), 16'(m_total)};
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_run_left = 0; m_cd_left = 0; m_total = 0;
        m_conc = 1'b0;   m_rej = 1'b0;
        model_outs();
    endtask

    task automatic model_step();
        m_conc = 1'b0;
        m_rej  = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (cmd_valid) begin
                    if (alerta) begin
                        m_rej = 1'b1; m_mode = M_FAULT;
                    end else if (cmd_tempo_ms == 0) begin
                        m_rej = 1'b1;
                    end else begin
                        m_mode = M_RUN;
                        m_run_left = ((int'(cmd_tempo_ms) > MX) ? MX : int'(cmd_tempo_ms)) * C;
                    end
                end else if (alerta) begin
                    m_mode = M_FAULT;
                end
            end
            M_RUN: begin
                m_rej = cmd_valid;
                if (alerta) m_mode = M_FAULT;
                else if (abort) begin
                    m_mode = M_COOL; m_cd_left = CD * C;
                end else begin
                    m_run_left--;
                    if (m_run_left == 0) begin
                        m_mode = M_COOL; m_cd_left = CD * C; m_conc = 1'b1;
                        m_total = (m_total >= 65535) ? 65535 : m_total + 1;
                    end
                end
            end
            M_COOL: begin
                m_rej = cmd_valid;
                if (alerta) m_mode = M_FAULT;
                else begin
                    m_cd_left--;
                    if (m_cd_left == 0) m_mode = M_IDLE;
                end
            end
            default: begin
                m_rej = cmd_valid;
                if (fault_clear && !alerta) m_mode = M_IDLE;
            end
        endcase
        model_outs();
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (obs !== 37'd0) begin
            n_errors++;
            $display("FAIL reset_state: dut=%h want=0", obs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        int on_cnt = 0, busy_cnt = 0, conc_cnt = 0;
        cmd_tempo_ms = 16'd5;
        cmd_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            cycle();
            cmd_valid = 1'b0;
            on_cnt   += int'(bomba_on);
            busy_cnt += int'(ocupado);
            conc_cnt += int'(ciclo_concluido);
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL normal cyc %0d: dut=%h model=%h", i, obs, exp_vec);
            end
        end
        n_checks++;
        if (on_cnt != 20) begin
            n_errors++; $display("FAIL normal_on_cycles: got %0d want 20", on_cnt);
        end
        n_checks++;
        if (busy_cnt != 32) begin
            n_errors++; $display("FAIL normal_busy_cycles: got %0d want 32", busy_cnt);
        end
        n_checks++;
        if (conc_cnt != 1 || total_ciclos !== 16'd1) begin
            n_errors++;
            $display("FAIL normal_done: pulses %0d total %0d want 1/1", conc_cnt, total_ciclos);
        end
    endtask

    task automatic test_fault();
        cmd_tempo_ms = 16'd10;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 9)  alerta = 1'b1;
            if (i == 12) fault_clear = 1'b1;
            if (i == 15) alerta = 1'b0;
            if (i == 16) fault_clear = 1'b0;
            cycle();
            cmd_valid = 1'b0;
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL fault cyc %0d: dut=%h model=%h", i, obs, exp_vec);
            end
            if (i == 9) begin
                n_checks++;
                if (bomba_on !== 1'b0 || falha_nivel !== 1'b1) begin
                    n_errors++;
                    $display("FAIL fault_entry: bomba_on=%b falha=%b want 0/1", bomba_on, falha_nivel);
                end
            end
            if (i == 14) begin
                n_checks++;
                if (falha_nivel !== 1'b1) begin
                    n_errors++; $display("FAIL fault_hold: falha=%b want 1", falha_nivel);
                end
            end
            if (i == 15) begin
                n_checks++;
                if (ocupado !== 1'b0 || falha_nivel !== 1'b0) begin
                    n_errors++;
                    $display("FAIL fault_exit: ocupado=%b falha=%b want 0/0", ocupado, falha_nivel);
                end
            end
        end
    endtask

    task automatic test_clamp();
        int on_cnt = 0;
        cmd_tempo_ms = 16'd250;
        cmd_valid = 1'b1;
        for (int i = 0; i < 420; i++) begin
            cycle();
            cmd_valid = 1'b0;
            on_cnt += int'(bomba_on);
            if (i == 0) begin
                n_checks++;
                if (tempo_restante_ms !== 16'd100) begin
                    n_errors++; $display("FAIL clamp_load: got %0d want 100", tempo_restante_ms);
                end
            end
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL clamp cyc %0d: dut=%h model=%h", i, obs, exp_vec);
            end
        end
        n_checks++;
        if (on_cnt != 400) begin
            n_errors++; $display("FAIL clamp_on_cycles: got %0d want 400", on_cnt);
        end
    endtask

    task automatic test_reject();
        for (int i = 0; i < 45; i++) begin
            cmd_valid = (i == 0 || i == 2 || i == 8);
            cmd_tempo_ms = (i == 0) ? 16'd0 : ((i == 2) ? 16'd6 : 16'd50);
            cycle();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL reject cyc %0d: dut=%h model=%h", i, obs, exp_vec);
            end
            if (i == 0 || i == 8) begin
                n_checks++;
                if (cmd_rejeitado !== 1'b1) begin
                    n_errors++; $display("FAIL reject_pulse cyc %0d: got %b want 1", i, cmd_rejeitado);
                end
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_abort();
        int tot0;
        tot0 = m_total;
        for (int i = 0; i < 50; i++) begin
            cmd_valid   = (i == 0 || i == 12);
            cmd_tempo_ms = 16'd8;
            abort       = (i == 7 || i == 22 || i == 26);
            alerta      = (i == 7);
            fault_clear = (i == 9);
            cycle();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL abort cyc %0d: dut=%h model=%h", i, obs, exp_vec);
            end
            if (i == 7) begin
                n_checks++;
                if (falha_nivel !== 1'b1) begin
                    n_errors++; $display("FAIL abort_vs_alerta: falha=%b want 1", falha_nivel);
                end
            end
        end
        n_checks++;
        if (total_ciclos !== 16'(tot0)) begin
            n_errors++; $display("FAIL abort_total: got %0d want %0d", total_ciclos, tot0);
        end
        cmd_valid = 1'b0; abort = 1'b0; alerta = 1'b0; fault_clear = 1'b0;
    endtask

    task automatic test_random();
        int hold = 0;
        int r;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0 && $urandom_range(0, 299) == 0) hold = $urandom_range(1, 6);
            alerta = (hold > 0);
            if (hold > 0) hold--;
            fault_clear = ($urandom_range(0, 7) == 0);
            abort       = ($urandom_range(0, 79) == 0);
            cmd_valid   = ($urandom_range(0, 14) == 0);
            r = $urandom_range(0, 9);
            cmd_tempo_ms = (r == 0) ? 16'd0 : ((r == 9) ? 16'($urandom_range(95, 140))
                                                        : 16'($urandom_range(1, 6)));
            cycle();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL random cyc %0d: dut=%h model=%h", i, obs, exp_vec);
            end
        end
        cmd_valid = 1'b0; abort = 1'b0; alerta = 1'b0; fault_clear = 1'b0;
        repeat (20) cycle();
    endtask

    task automatic test_reset_midrun();
        cmd_tempo_ms = 16'd7;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        repeat (5) cycle();
        n_checks++;
        if (bomba_on !== 1'b1) begin
            n_errors++; $display("FAIL midrun_pre: bomba_on=%b want 1", bomba_on);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs !== 37'd0) begin
            n_errors++; $display("FAIL midrun_async: dut=%h want 0", obs);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 37'd0) begin
            n_errors++; $display("FAIL midrun_held: dut=%h want 0", obs);
        end
        rst_n = 1'b1;
        cmd_tempo_ms = 16'd3;
        cmd_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            cmd_valid = 1'b0;
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL post_reset cyc %0d: dut=%h model=%h", i, obs, exp_vec);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_normal();
        test_fault();
        test_clamp();
        test_reject();
        test_abort();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/controlador_bomba.md
CONTROLADOR_BOMBA -- requirements
Module: controlador_bomba

Interface
REQ-001 SHALL have parameter CYCLES_PER_MS, default 50000, meaning clk cycles per millisecond tick.
REQ-002 SHALL have parameter COOLDOWN_MS, default 2000, meaning the mandatory pump rest time after any run, in ms.
REQ-003 SHALL have parameter MAX_MS, default 60000, meaning the absolute run-time ceiling, in ms.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_tempo_ms, input, 16 bits: requested run time in ms, taken from the irrigation decision stage.
REQ-007 SHALL have port cmd_valid, input, 1 bit: one-cycle start request that qualifies cmd_tempo_ms.
REQ-008 SHALL have port alerta_nivel_baixo, input, 1 bit: reservoir low-level alarm.
REQ-009 SHALL have port abort, input, 1 bit: operator stop request.
REQ-010 SHALL have port fault_clear, input, 1 bit: acknowledge of a level fault.
REQ-011 SHALL have port bomba_on, output, 1 bit, registered: pump drive.
REQ-012 SHALL have port ocupado, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port tempo_restante_ms, output, 16 bits: remaining run time in ms.
REQ-014 SHALL have port ciclo_concluido, output, 1 bit: one-cycle pulse on normal completion.
REQ-015 SHALL have port cmd_rejeitado, output, 1 bit: one-cycle pulse when a request is refused.
REQ-016 SHALL have port falha_nivel, output, 1 bit: high while in FAULT.
REQ-017 SHALL have port total_ciclos, output, 16 bits: count of completed runs, saturating at 16'hFFFF.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, COOLDOWN and FAULT.
REQ-019 Prescaler SHALL count 0..CYCLES_PER_MS-1 during RUN and COOLDOWN, produce ms tick at terminal count, and clear on every state entry.
REQ-020 IDLE, cmd_valid=1, alerta=0, cmd_tempo_ms!=0: SHALL load tempo_restante_ms with min(cmd_tempo_ms, MAX_MS) and enter RUN next cycle.
REQ-021 IDLE, cmd_valid=1, cmd_tempo_ms=0, alerta=0: SHALL pulse cmd_rejeitado and remain in IDLE.
REQ-022 IDLE, cmd_valid=1, alerta=1: SHALL pulse cmd_rejeitado and enter FAULT.
REQ-023 IDLE, alerta=1 without cmd_valid: SHALL enter FAULT.
REQ-024 cmd_valid outside IDLE: SHALL pulse cmd_rejeitado with no effect on state or counters.
REQ-025 bomba_on SHALL be 1 exactly in RUN, asserted the cycle after the accepting cmd_valid, for exactly N*CYCLES_PER_MS cycles, where N is the loaded value.
REQ-026 In RUN, each ms tick SHALL decrement tempo_restante_ms; the tick that reaches 0 SHALL move to COOLDOWN, pulse ciclo_concluido in the first COOLDOWN cycle and increment total_ciclos.
REQ-027 In RUN, abort=1 SHALL enter COOLDOWN next cycle with no ciclo_concluido pulse, no increment and tempo_restante_ms cleared to 0.
REQ-028 In RUN or COOLDOWN, alerta=1 SHALL enter FAULT next cycle and drop bomba_on that cycle.
REQ-029 Priority within a cycle SHALL be: alerta > abort > completion tick.
REQ-030 COOLDOWN SHALL last COOLDOWN_MS*CYCLES_PER_MS cycles, then return to IDLE; abort SHALL be ignored there.
REQ-031 FAULT SHALL exit to IDLE only when fault_clear=1 and alerta=0 in the same cycle; tempo_restante_ms SHALL read 0 in FAULT.
REQ-032 Counters SHALL be sized for the parameters; the run counter SHALL never underflow or wrap.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and clear bomba_on, ocupado, tempo_restante_ms, ciclo_concluido, cmd_rejeitado, falha_nivel, total_ciclos and the prescaler, including mid-run.
REQ-034 The first request SHALL be accepted on the first clk edge after rst_n deasserts.

Verification (CYCLES_PER_MS=4, COOLDOWN_MS=3, MAX_MS=100)
REQ-035 cmd 5 with cmd_valid -> bomba_on high for 20 cycles starting the next cycle; ciclo_concluido pulse; ocupado high 12 further cycles; total_ciclos=1.
REQ-036 cmd 10, alerta=1 at cycle 9 -> bomba_on=0 next cycle; falha_nivel=1; fault_clear with alerta=1 -> stays in FAULT; alerta=0 plus fault_clear -> IDLE.
REQ-037 cmd 250 -> tempo_restante_ms=100, bomba_on for 400 cycles.
REQ-038 cmd 0 in IDLE -> cmd_rejeitado pulse, ocupado=0; cmd_valid during RUN -> cmd_rejeitado pulse, tempo_restante_ms unaffected.
REQ-039 abort and alerta in the same RUN cycle -> FAULT; abort alone -> COOLDOWN, no ciclo_concluido, total_ciclos unchanged.
REQ-040 rst_n low for 1 cycle mid-RUN -> bomba_on=0 asynchronously, all outputs 0, IDLE after release.
